// File: rtl/serial_chunk_adder_pkg.sv
// Shared types and helpers for the serial chunk adder.
package serial_chunk_adder_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Chunk counter width: holds 0..nchunk-1, never narrower than one bit.
    function automatic int cnt_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/serial_chunk_adder_chunk_add.sv
// Combinational CHUNK-bit ripple adder; also reports the carry into its top bit.
module chunk_add #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder: WIDTH-bit operands summed CHUNK bits per clock.
// Optional subtract port enabled by SERIAL_CHUNK_ADDER_SUB_EN.
module serial_chunk_adder
    import serial_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    input  logic             i_sub,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_ovf,
    output state_t           o_state
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_w(NCHUNK);

    // Handshake: i_start is taken only on an edge where the unit is IDLE
    // (o_busy=0); o_busy stays high through the RUN edges, and o_done pulses
    // one cycle as o_sum/o_carry/o_ovf update. Starts seen while busy are dropped.

    state_t state, state_next;

    logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_next;
    logic [WIDTH-1:0] b_load;
    logic             cin_load;
    logic             carry_reg;
    logic [CW-1:0]    count;
    logic [CHUNK-1:0] ch_sum;
    logic             ch_cout, ch_cmsb;
    logic             accept, last;

`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    // Subtraction is A + ~B + ~borrow_in.
    assign b_load   = i_sub ? ~i_b : i_b;
    assign cin_load = i_carry ^ i_sub;
`else
    assign b_load   = i_b;
    assign cin_load = i_carry;
`endif

    assign accept = (state == IDLE) && i_start;
    assign last   = (state == RUN) && (count == CW'(NCHUNK - 1));

    chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
        .a        (a_sr[CHUNK-1:0]),
        .b        (b_sr[CHUNK-1:0]),
        .cin      (carry_reg),
        .sum      (ch_sum),
        .cout     (ch_cout),
        .c_msb_in (ch_cmsb)
    );

    // Each chunk sum enters at the top so the result ends LSB-aligned.
    generate
        if (CHUNK == WIDTH) begin : g_single
            assign sum_next = ch_sum;
        end else begin : g_multi
            assign sum_next = {ch_sum, sum_sr[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = RUN;
            RUN:     if (last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy  = (state == RUN);
        o_state = state;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
            carry_reg <= 1'b0;
            count     <= '0;
            o_sum     <= '0;
            o_carry   <= 1'b0;
            o_ovf     <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_done <= last;
            if (accept) begin
                a_sr      <= i_a;
                b_sr      <= b_load;
                carry_reg <= cin_load;
                count     <= '0;
            end else if (state == RUN) begin
                a_sr      <= a_sr >> CHUNK;
                b_sr      <= b_sr >> CHUNK;
                sum_sr    <= sum_next;
                carry_reg <= ch_cout;
                count     <= count + 1'b1;
                if (last) begin
                    count   <= '0;
                    o_sum   <= sum_next;
                    o_carry <= ch_cout;
                    o_ovf   <= ch_cout ^ ch_cmsb;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Bench for serial_chunk_adder: WIDTH=8 with CHUNK=1,2,4,8 side by side.
module tb_serial_chunk_adder;
    import serial_chunk_adder_pkg::*;

    localparam int W    = 8;
    localparam int NI   = 4;
    localparam int MAIN = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in, b_in;
    logic         cin_in;
    logic         sub_in;

    logic [W-1:0] sum_w   [NI];
    logic         busy_w  [NI];
    logic         done_w  [NI];
    logic         carry_w [NI];
    logic         ovf_w   [NI];
    state_t       state_w [NI];

    int           nch     [NI];
    logic [W+1:0] prev    [NI];
    logic [W+1:0] exp_q   [$];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        serial_chunk_adder #(.WIDTH(W), .CHUNK(1 << g)) u_dut (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_start (start),
            .i_a     (a_in),
            .i_b     (b_in),
            .i_carry (cin_in),
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
            .i_sub   (sub_in),
`endif
            .o_busy  (busy_w[g]),
            .o_done  (done_w[g]),
            .o_sum   (sum_w[g]),
            .o_carry (carry_w[g]),
            .o_ovf   (ovf_w[g]),
            .o_state (state_w[g])
        );
    end

    // Reference: plain integer add of the (possibly inverted) operands.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, b, input logic cin, sub);
        logic [W-1:0] bb;
        logic         c, ovf;
        logic [W:0]   s;
        bb  = sub ? ~b : b;
        c   = sub ? ~cin : cin;
        s   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
        ovf = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
        return {ovf, s[W], s[W-1:0]};
    endfunction

    function automatic logic [W+1:0] result(input int g);
        return {ovf_w[g], carry_w[g], sum_w[g]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, b, input logic cin, sub, input bit poke);
        logic [W+1:0] exp;
        logic         eff_sub;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
        eff_sub = sub;
`else
        eff_sub = 1'b0;
`endif
        exp    = model(a, b, cin, eff_sub);
        a_in   = a;
        b_in   = b;
        cin_in = cin;
        sub_in = sub;
        start  = 1'b1;
        step();
        start  = 1'b0;
        a_in   = W'($urandom);
        b_in   = W'($urandom);
        cin_in = 1'($urandom);
        for (int k = 0; k <= W; k++) begin
            if (k > 0) step();
            for (int g = 0; g < NI; g++) begin
                check($sformatf("busy_c%0d_k%0d", 1 << g, k), 32'(busy_w[g]), 32'(k < nch[g]));
                check($sformatf("done_c%0d_k%0d", 1 << g, k), 32'(done_w[g]), 32'(k == nch[g]));
                if (k == nch[g]) begin
                    check($sformatf("result_c%0d", 1 << g), 32'(result(g)), 32'(exp));
                    prev[g] = exp;
                end else if (k < nch[g]) begin
                    check($sformatf("hold_c%0d_k%0d", 1 << g, k), 32'(result(g)), 32'(prev[g]));
                end
            end
            if (poke && k == 0) begin
                start = 1'b1;
                a_in  = 8'hAA;
            end else if (poke && k == 1) begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        for (int g = 0; g < NI; g++) begin
            nch[g]  = W / (1 << g);
            prev[g] = '0;
        end
        rst    = 1'b1;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        cin_in = 1'b0;
        sub_in = 1'b0;
        step();
        step();
        for (int g = 0; g < NI; g++) begin
            check($sformatf("rst_busy_c%0d", 1 << g), 32'(busy_w[g]), 32'd0);
            check($sformatf("rst_done_c%0d", 1 << g), 32'(done_w[g]), 32'd0);
            check($sformatf("rst_result_c%0d", 1 << g), 32'(result(g)), 32'd0);
            check($sformatf("rst_state_c%0d", 1 << g), 32'(state_w[g]), 32'(IDLE));
        end
        rst = 1'b0;
        step();

        run_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
        check("basic_sum", 32'(sum_w[MAIN]), 32'h46);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        check("wrap_carry", 32'(carry_w[MAIN]), 32'd1);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        check("ovf_flag", 32'(ovf_w[MAIN]), 32'd1);
        run_op(8'h0F, 8'h00, 1'b1, 1'b0, 1'b1);
        check("cin_cross", 32'(sum_w[MAIN]), 32'h10);

        // Start held high: CHUNK=4 instance accepts on every third edge.
        exp_q.delete();
        start = 1'b1;
        for (int j = 0; j < 12; j++) begin
            a_in   = W'($urandom);
            b_in   = W'($urandom);
            cin_in = 1'($urandom);
            sub_in = 1'b0;
            if (j % 3 == 0) exp_q.push_back(model(a_in, b_in, cin_in, 1'b0));
            step();
            check($sformatf("b2b_done_j%0d", j), 32'(done_w[MAIN]), 32'(j % 3 == 2));
            if (done_w[MAIN] && exp_q.size() > 0) begin
                check($sformatf("b2b_result_j%0d", j), 32'(result(MAIN)), 32'(exp_q.pop_front()));
            end
        end
        start = 1'b0;
        check("b2b_drained", 32'(exp_q.size()), 32'd0);
        for (int j = 0; j < 10; j++) step();

        // Reset one cycle after accept aborts without a done pulse.
        a_in   = 8'h21;
        b_in   = 8'h43;
        cin_in = 1'b0;
        start  = 1'b1;
        step();
        start  = 1'b0;
        step();
        rst    = 1'b1;
        #1;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("abort_busy_c%0d", 1 << g), 32'(busy_w[g]), 32'd0);
            check($sformatf("abort_result_c%0d", 1 << g), 32'(result(g)), 32'd0);
            prev[g] = '0;
        end
        for (int j = 0; j < 3; j++) begin
            step();
            check($sformatf("abort_done_j%0d", j), 32'(done_w[MAIN]), 32'd0);
        end
        rst = 1'b0;
        step();
        run_op(8'h33, 8'h44, 1'b1, 1'b0, 1'b0);

`ifdef SERIAL_CHUNK_ADDER_SUB_EN
        run_op(8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
        check("sub_sum", 32'(sum_w[MAIN]), 32'hFE);
        check("sub_borrow", 32'(carry_w[MAIN]), 32'd0);
`endif

        for (int r = 0; r < 10; r++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
